argmax_unit: RTL
================

ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 SHALL have parameter NEURON_NB, default 10: number of input elements.
REQ-002 SHALL have parameter WIDTH, default 16: element width in bits.
REQ-003 SHALL have parameter LANES, default 2: elements compared per cycle, range 1..NEURON_NB.
REQ-004 SHALL have parameter IDX_W, default 4: index width, at least clog2(NEURON_NB).
REQ-005 SHALL have parameter SIGNED_MODE, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-006 SHALL have parameter RELU_MODE, default 1: 1 = elements with MSB set are not candidates.
REQ-007 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-008 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port start, input, 1 bit: request a new scan.
REQ-010 SHALL have port in_data, input, WIDTH*NEURON_NB bits: element k at bits [WIDTH*k +: WIDTH].
REQ-011 SHALL have port tie_last, input, 1 bit: 1 = highest index wins ties, 0 = lowest index wins.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port busy, output, 1 bit: high in SCAN or HOLD.
REQ-014 SHALL have port out_valid, output, 1 bit: result valid, high in HOLD.
REQ-015 SHALL have port digit, output, IDX_W bits: index of the winning element.
REQ-016 SHALL have port max_val, output, WIDTH bits: value of the winning element.
REQ-017 SHALL have port margin, output, WIDTH bits: winner minus runner-up, saturating.
REQ-018 SHALL have port none_valid, output, 1 bit: no element qualified as a candidate.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN and HOLD.
REQ-020 IDLE with start=1 SHALL snapshot in_data and tie_last, clear best, second, ptr and found, and go to SCAN; in_data changes after that edge SHALL have no effect.
REQ-021 SCAN SHALL, each cycle, evaluate elements ptr..ptr+LANES-1 in ascending index order, then advance ptr by LANES.
REQ-022 Lane indices >= NEURON_NB in the final partial group SHALL be ignored.
REQ-023 A candidate SHALL become best if found=0, or if it is greater than best, or if it is equal to best and tie_last=1.
REQ-024 When a candidate replaces best, the old best SHALL move to second; otherwise the candidate SHALL replace second if it is greater than second, or if second is unset.
REQ-025 SCAN SHALL last exactly ceil(NEURON_NB/LANES) cycles and then go to HOLD; out_valid SHALL rise on the edge after the last SCAN cycle (start to out_valid latency = ceil(NEURON_NB/LANES)+1 edges).
REQ-026 HOLD SHALL keep out_valid and all result outputs stable until out_ready=1, then go to IDLE on that edge.
REQ-027 start SHALL be ignored in SCAN and HOLD, including start=1 in the same cycle as the HOLD-exit out_ready.
REQ-028 If there are no candidates: digit=0, max_val=0, margin=0, none_valid=1.
REQ-029 If there is exactly one candidate: margin SHALL be all-ones.
REQ-030 margin SHALL be computed as best minus second in WIDTH+1 bits, clamped to all-ones on overflow; it SHALL never be negative.
REQ-031 With RELU_MODE=0, every element SHALL be a candidate.
REQ-032 digit, max_val, margin and none_valid SHALL be registered and SHALL change only on SCAN-to-HOLD entry or on reset.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE and busy=0, out_valid=0, digit=0, max_val=0, margin=0, none_valid=0, ptr=0.
REQ-034 Reset asserted mid-SCAN or in HOLD SHALL abort the operation with no result; the first start after reset deassertion SHALL behave as from power-up.

Verification
REQ-035 Bench SHALL cover defaults, in_data = {3,7,2,9,9,1,0,4,5,8} (element 0 first), tie_last=0, out_ready=1: digit=3, max_val=9, margin=0, out_valid 6 edges after start.
REQ-036 Bench SHALL cover the same data with tie_last=1: digit=4, max_val=9, margin=0.
REQ-037 Bench SHALL cover RELU_MODE=1 with all elements 16'h8000..16'hFFFF: none_valid=1, digit=0, max_val=0, margin=0.
REQ-038 Bench SHALL cover a single candidate 5 at index 7, others negative: digit=7, max_val=5, margin=16'hFFFF, none_valid=0.
REQ-039 Bench SHALL cover LANES=3, NEURON_NB=10, max at index 9: out_valid 5 edges after start; out_ready held low 3 cycles keeps outputs stable; start pulsed in HOLD is ignored.
REQ-040 Bench SHALL cover reset asserted in the 2nd SCAN cycle: all outputs 0 immediately; a new start then yields the correct result from fresh data.

Source files
------------

// File: rtl/argmax_unit.sv
// argmax_unit: scans NEURON_NB elements LANES at a time and reports the index and value
// of the largest candidate, plus the saturating margin to the runner-up.
module argmax_unit #(
    parameter int unsigned NEURON_NB   = 10,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LANES       = 2,
    parameter int unsigned IDX_W       = 4,
    parameter bit          SIGNED_MODE = 1'b1,
    parameter bit          RELU_MODE   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH*NEURON_NB-1:0] in_data,
    input  logic                       tie_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           digit,
    output logic [WIDTH-1:0]           max_val,
    output logic [WIDTH-1:0]           margin,
    output logic                       none_valid
);

    localparam int unsigned DATA_W = WIDTH * NEURON_NB;
    // Pointer must hold one group past the last element without wrapping.
    localparam int unsigned PTR_W = $clog2(NEURON_NB + LANES + 1);
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(LANES);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e state_q, state_d;

    // Scan context. The snapshot shifts down by one group per SCAN cycle so the
    // current group always sits in the low LANES*WIDTH bits.
    logic [DATA_W-1:0] snap_q;
    logic              tie_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [WIDTH-1:0]  best_q, best_d;
    logic [WIDTH-1:0]  second_q, second_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              found_q, found_d;
    logic              second_set_q, second_set_d;

    // Registered result.
    logic [IDX_W-1:0]  digit_q;
    logic [WIDTH-1:0]  max_val_q;
    logic [WIDTH-1:0]  margin_q, margin_d;
    logic              none_valid_q;

    // FSM strobes.
    logic scan_load;
    logic scan_step;
    logic scan_done;
    logic last_group;

    // Lane working variables.
    logic [31:0]      lane_idx;
    logic [WIDTH-1:0] lane_val;
    logic [WIDTH:0]   best_ext;
    logic [WIDTH:0]   second_ext;
    logic [WIDTH:0]   diff;

    function automatic logic is_cand(input logic [WIDTH-1:0] v);
        return RELU_MODE ? ~v[WIDTH-1] : 1'b1;
    endfunction

    function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED_MODE) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // The current group is the final one once it reaches or passes the last element.
    assign last_group = (32'(ptr_q) + LANES) >= NEURON_NB;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, status outputs and datapath strobes.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        out_valid = 1'b0;
        scan_load = 1'b0;
        scan_step = 1'b0;
        scan_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    scan_load = 1'b1;
                    state_d   = StScan;
                end
            end
            StScan: begin
                busy      = 1'b1;
                scan_step = 1'b1;
                if (last_group) begin
                    scan_done = 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // start is deliberately not looked at here, even on the exit edge.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Fold the current group into best/second, lanes in ascending index order.
    always_comb begin
        best_d       = best_q;
        second_d     = second_q;
        best_idx_d   = best_idx_q;
        found_d      = found_q;
        second_set_d = second_set_q;
        lane_idx     = '0;
        lane_val     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx = 32'(ptr_q) + l;
            lane_val = WIDTH'(snap_q >> (WIDTH * l));
            // Lanes past the end of the vector in the last partial group are dropped.
            if (lane_idx < NEURON_NB && is_cand(lane_val)) begin
                if (!found_d || greater(lane_val, best_d) ||
                    ((lane_val == best_d) && tie_q)) begin
                    if (found_d) begin
                        second_d     = best_d;
                        second_set_d = 1'b1;
                    end
                    best_d     = lane_val;
                    best_idx_d = lane_idx[IDX_W-1:0];
                    found_d    = 1'b1;
                end else if (!second_set_d || greater(lane_val, second_d)) begin
                    second_d     = lane_val;
                    second_set_d = 1'b1;
                end
            end
        end
    end

    // Margin in WIDTH+1 bits; best never sits below second, so bit WIDTH only flags overflow.
    always_comb begin
        best_ext   = SIGNED_MODE ? {best_d[WIDTH-1], best_d} : {1'b0, best_d};
        second_ext = SIGNED_MODE ? {second_d[WIDTH-1], second_d} : {1'b0, second_d};
        diff       = best_ext - second_ext;
        if (!found_d) begin
            margin_d = '0;
        end else if (!second_set_d || diff[WIDTH]) begin
            margin_d = '1;
        end else begin
            margin_d = diff[WIDTH-1:0];
        end
    end

    // Scan context: cleared on start, advanced one group per SCAN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q       <= '0;
            tie_q        <= 1'b0;
            ptr_q        <= '0;
            best_q       <= '0;
            second_q     <= '0;
            best_idx_q   <= '0;
            found_q      <= 1'b0;
            second_set_q <= 1'b0;
        end else if (scan_load) begin
            snap_q       <= in_data;
            tie_q        <= tie_last;
            ptr_q        <= '0;
            best_q       <= '0;
            second_q     <= '0;
            best_idx_q   <= '0;
            found_q      <= 1'b0;
            second_set_q <= 1'b0;
        end else if (scan_step) begin
            snap_q       <= snap_q >> (WIDTH * LANES);
            ptr_q        <= ptr_q + PTR_STEP;
            best_q       <= best_d;
            second_q     <= second_d;
            best_idx_q   <= best_idx_d;
            found_q      <= found_d;
            second_set_q <= second_set_d;
        end
    end

    // Result registers only move when the last group has been folded in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q      <= '0;
            max_val_q    <= '0;
            margin_q     <= '0;
            none_valid_q <= 1'b0;
        end else if (scan_done) begin
            digit_q      <= found_d ? best_idx_d : '0;
            max_val_q    <= found_d ? best_d : '0;
            margin_q     <= margin_d;
            none_valid_q <= ~found_d;
        end
    end

    assign digit      = digit_q;
    assign max_val    = max_val_q;
    assign margin     = margin_q;
    assign none_valid = none_valid_q;

endmodule
